fetch_sequencer: RTL and testbench

Controller that sequences the 8-entry instruction store. It fetches a programmed number of 32-bit MIPS instructions in order and decodes each one as R, I or J type. Each decoded instruction is issued to the downstream execute stage over a valid/ready handshake. Per-type counts and per-destination write counts for registers 3–6 are kept and exposed to the rest of the design.

---
 rtl/fetch_pkg.sv | 33 +++
 rtl/prog_mem.sv | 31 +++
 rtl/fetch_sequencer.sv | 154 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the instruction fetch sequencer.
//   - MIPS opcode values used by the decoder
//   - issue type encoding driven on issue_type
//   - sequencer state encoding
//   - destination register window tracked by the write counters
package fetch_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_JAL   = 6'd3;

   typedef enum logic [1:0] {
      TYPE_R = 2'b00,
      TYPE_I = 2'b01,
      TYPE_J = 2'b10
   } itype_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [4:0] REG_LO    = 5'd3;
   localparam logic [4:0] REG_HI    = 5'd6;
   localparam int         NUM_WREGS = 4;

   function automatic logic is_wreg(input logic [4:0] r);
      return (r >= REG_LO) && (r <= REG_HI);
   endfunction

endpackage

// File: rtl/prog_mem.sv
// prog_mem: DEPTH x 32 instruction store.
//   clk, rst_n      clock, async active-low reset (read register only)
//   we/waddr/wdata  synchronous write port
//   re/raddr/rdata  registered read port; rdata holds while re is low
// Array contents are not reset.
module prog_mem #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: runs a programmed number of words from the instruction
// store, decodes each as R/I/J and issues it over a valid/ready handshake,
// keeping per-type counts and write counts for destinations 3..6.
//   prog_we/prog_addr/prog_data  store write port (ignored while busy)
//   start/num_instr              run request and word count (IDLE/DONE only)
//   issue_*                      decoded instruction, valid/ready handshake
//   busy/done                    run status
//   rcount/icount/jcount/wcount  saturating counters, wcount reg 3 in LSBs
//
// state | meaning
// IDLE  | after reset, waiting for start
// FETCH | read address pc presented to the store
// ISSUE | decoded word presented, waiting for issue_ready
// DONE  | run complete, counters held until next start
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int CW    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   prog_we,
   input  logic [AW-1:0]          prog_addr,
   input  logic [31:0]            prog_data,
   input  logic                   start,
   input  logic [AW:0]            num_instr,
   output logic                   issue_valid,
   input  logic                   issue_ready,
   output logic [31:0]            issue_instr,
   output logic [AW-1:0]          issue_pc,
   output logic [1:0]             issue_type,
   output logic [4:0]             issue_dst,
   output logic                   issue_wen,
   output logic                   busy,
   output logic                   done,
   output logic [CW-1:0]          rcount,
   output logic [CW-1:0]          icount,
   output logic [CW-1:0]          jcount,
   output logic [NUM_WREGS*CW-1:0] wcount
);

   localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   state_t      state, state_nx;
   logic [AW:0] pc, pc_inc, count_lat;
   logic [31:0] word;
   logic [5:0]  opcode;
   itype_t      typ;
   logic [4:0]  dst;
   logic        mem_re, start_ok, hs;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   prog_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (prog_we && !busy),
      .waddr (prog_addr),
      .wdata (prog_data),
      .re    (mem_re),
      .raddr (pc[AW-1:0]),
      .rdata (word)
   );

   // The store's read register is the issue register: it only loads in
   // FETCH, so every issue_* field stays stable through a stall.
   assign opcode = word[31:26];

   always_comb begin
      typ = TYPE_I;
      dst = word[20:16];
      if (opcode == OP_RTYPE) begin
         typ = TYPE_R;
         dst = word[15:11];
      end else if (opcode == OP_J || opcode == OP_JAL) begin
         typ = TYPE_J;
         dst = '0;
      end
   end

   assign issue_valid = (state == ISSUE);
   assign issue_instr = word;
   assign issue_pc    = pc[AW-1:0];
   assign issue_type  = typ;
   assign issue_dst   = dst;
   assign issue_wen   = (typ != TYPE_J) && (dst != 5'd0);
   assign busy        = (state == FETCH) || (state == ISSUE);
   assign done        = (state == DONE);

   assign start_ok = start && (state == IDLE || state == DONE);
   assign hs       = issue_valid && issue_ready;
   assign pc_inc   = pc + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      mem_re   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start_ok) state_nx = (num_instr == '0) ? DONE : FETCH;
         end
         FETCH: begin
            mem_re   = 1'b1;
            state_nx = ISSUE;
         end
         ISSUE: begin
            if (hs) state_nx = (pc_inc == count_lat) ? DONE : FETCH;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= '0;
         count_lat <= '0;
         rcount    <= '0;
         icount    <= '0;
         jcount    <= '0;
         wcount    <= '0;
      end else if (start_ok) begin
         // Counts above DEPTH are clamped so pc never has to pass DEPTH.
         count_lat <= (num_instr > DEPTH_CNT) ? DEPTH_CNT : num_instr;
         pc        <= '0;
         rcount    <= '0;
         icount    <= '0;
         jcount    <= '0;
         wcount    <= '0;
      end else if (hs) begin
         pc <= pc_inc;
         case (typ)
            TYPE_R:  rcount <= sat_inc(rcount);
            TYPE_J:  jcount <= sat_inc(jcount);
            default: icount <= sat_inc(icount);
         endcase
         if (issue_wen && is_wreg(dst)) begin
            for (int k = 0; k < NUM_WREGS; k++) begin
               if (dst == REG_LO + 5'(k))
                  wcount[k*CW +: CW] <= sat_inc(wcount[k*CW +: CW]);
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a scoreboard: runs push expected
// issue records, a negedge monitor compares whatever the DUT presents.
module tb_fetch_sequencer;

   localparam int AW = 3;
   localparam int CW = 4;

   localparam logic [1:0] TR = 2'b00;
   localparam logic [1:0] TI = 2'b01;
   localparam logic [1:0] TJ = 2'b10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          prog_we = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [31:0]   prog_data = '0;
   logic          start = 1'b0;
   logic [AW:0]   num_instr = '0;
   logic          issue_valid;
   logic          issue_ready = 1'b0;
   logic [31:0]   issue_instr;
   logic [AW-1:0] issue_pc;
   logic [1:0]    issue_type;
   logic [4:0]    issue_dst;
   logic          issue_wen;
   logic          busy, done;
   logic [CW-1:0] rcount, icount, jcount;
   logic [4*CW-1:0] wcount;

   fetch_sequencer #(.DEPTH(8), .AW(AW), .CW(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .start       (start),
      .num_instr   (num_instr),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_instr (issue_instr),
      .issue_pc    (issue_pc),
      .issue_type  (issue_type),
      .issue_dst   (issue_dst),
      .issue_wen   (issue_wen),
      .busy        (busy),
      .done        (done),
      .rcount      (rcount),
      .icount      (icount),
      .jcount      (jcount),
      .wcount      (wcount)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  pc;
      logic [31:0] instr;
      logic [1:0]  typ;
      logic [4:0]  dst;
      logic        wen;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] cur_word [8];
   logic [1:0]  cur_type [8];
   logic [4:0]  cur_dst  [8];
   logic        cur_wen  [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every cycle a word is presented it must match the head of the
   // queue (so a stalled word is re-checked each cycle); pop on handshake.
   always @(negedge clk) begin
      if (rst_n && issue_valid) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_issue: got pc %0d instr %08h expected no issue",
                     issue_pc, issue_instr);
         end else begin
            mon_e = exp_q[0];
            chk("issue_fields", {21'd0, issue_pc, issue_instr, issue_type, issue_dst, issue_wen},
                {21'd0, mon_e});
            if (issue_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic set_row(input int a, input logic [31:0] w, input logic [1:0] t,
                          input logic [4:0] d, input logic we, input bit wr);
      cur_word[a] = w;
      cur_type[a] = t;
      cur_dst[a]  = d;
      cur_wen[a]  = we;
      if (wr) begin
         prog_we   = 1'b1;
         prog_addr = 3'(a);
         prog_data = w;
         @(posedge clk);
         #1 prog_we = 1'b0;
      end
   endtask

   task automatic load_p1();
      set_row(0, 32'h2004_0001, TI, 5'd4, 1'b1, 1'b1); // ADDI $4
      set_row(1, 32'h2005_0002, TI, 5'd5, 1'b1, 1'b1); // ADDI $5
      set_row(2, 32'h0085_3020, TR, 5'd6, 1'b1, 1'b1); // ADD  $6,$4,$5
      set_row(3, 32'h2003_0007, TI, 5'd3, 1'b1, 1'b1); // ADDI $3
      set_row(4, 32'h0064_3004, TR, 5'd6, 1'b1, 1'b1); // SLLV $6,$4,$3
      set_row(5, 32'h0006_1882, TR, 5'd3, 1'b1, 1'b1); // SRL  $3,$6,2
      set_row(6, 32'h8C05_0000, TI, 5'd5, 1'b1, 1'b1); // LW   $5
      set_row(7, 32'h0800_0000, TJ, 5'd0, 1'b0, 1'b1); // J
   endtask

   task automatic push_exp(input int num);
      exp_t e;
      for (int k = 0; k < num; k++) begin
         e.pc    = 3'(k);
         e.instr = cur_word[k];
         e.typ   = cur_type[k];
         e.dst   = cur_dst[k];
         e.wen   = cur_wen[k];
         exp_q.push_back(e);
      end
   endtask

   task automatic chk_counts(input string tag, input logic [CW-1:0] r, input logic [CW-1:0] i,
                             input logic [CW-1:0] j, input logic [4*CW-1:0] w);
      chk({tag, "_rcount"}, 64'(rcount), 64'(r));
      chk({tag, "_icount"}, 64'(icount), 64'(i));
      chk({tag, "_jcount"}, 64'(jcount), 64'(j));
      chk({tag, "_wcount"}, 64'(wcount), 64'(w));
   endtask

   // One run: start, optional 3-cycle stall per word, optional mid-run
   // start/prog_we pulse, optional word-0 write together with start.
   task automatic run(input string tag, input int num, input bit stall, input bit disturb,
                      input bit we0, input logic [31:0] we0_data, input int exp_cyc);
      int cyc;
      int stall_cnt;
      push_exp(num);
      issue_ready = !stall;
      start       = 1'b1;
      num_instr   = 4'(num);
      if (we0) begin
         prog_we   = 1'b1;
         prog_addr = 3'd0;
         prog_data = we0_data;
      end
      @(posedge clk);
      #1;
      start     = 1'b0;
      prog_we   = 1'b0;
      cyc       = 1;
      stall_cnt = 0;
      while (!done && cyc < 200) begin
         if (stall && issue_valid) begin
            if (stall_cnt < 3) begin
               issue_ready = 1'b0;
               stall_cnt++;
            end else begin
               issue_ready = 1'b1;
               stall_cnt   = 0;
            end
         end
         @(posedge clk);
         #1;
         cyc++;
         if (disturb && cyc == 4) begin
            start     = 1'b1;
            num_instr = 4'd1;
            prog_we   = 1'b1;
            prog_addr = 3'd7;
            prog_data = 32'h0800_0000;
         end else if (disturb && cyc == 5) begin
            start   = 1'b0;
            prog_we = 1'b0;
         end
      end
      chk({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
      chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
      chk({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin : stim
      int cyc;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(issue_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_instr", 64'(issue_instr), 64'd0);
      chk_counts("rst", 4'd0, 4'd0, 4'd0, 16'h0000);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      load_p1();
      run("p1", 8, 1'b0, 1'b0, 1'b0, 32'h0, 17);
      chk_counts("p1", 4'd3, 4'd4, 4'd1, 16'h2212);

      run("stall", 8, 1'b1, 1'b0, 1'b0, 32'h0, 41);
      chk_counts("stall", 4'd3, 4'd4, 4'd1, 16'h2212);

      run("zero", 0, 1'b0, 1'b0, 1'b0, 32'h0, 1);
      chk("zero_done", 64'(done), 64'd1);
      chk_counts("zero", 4'd0, 4'd0, 4'd0, 16'h0000);

      // Reset while the third word is being issued.
      push_exp(8);
      issue_ready = 1'b1;
      start       = 1'b1;
      num_instr   = 4'd8;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 1;
      while (!(issue_valid && issue_pc == 3'd2) && cyc < 30) begin
         @(posedge clk);
         #1 cyc++;
      end
      chk("rst_mid_reached_pc2", 64'(issue_valid && issue_pc == 3'd2), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", 64'(issue_valid), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_done", 64'(done), 64'd0);
      chk_counts("rst_mid", 4'd0, 4'd0, 4'd0, 16'h0000);
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      run("after_rst", 8, 1'b0, 1'b0, 1'b0, 32'h0, 17);
      chk_counts("after_rst", 4'd3, 4'd4, 4'd1, 16'h2212);

      for (int n = 0; n < 20; n++) begin
         run("rep", 8, 1'b0, 1'b0, 1'b0, 32'h0, 17);
         chk_counts("rep", 4'd3, 4'd4, 4'd1, 16'h2212);
      end

      for (int a = 0; a < 8; a++)
         set_row(a, 32'h0022_1820, TR, 5'd3, 1'b1, 1'b1); // ADD $3,$1,$2
      run("allr3", 8, 1'b0, 1'b1, 1'b0, 32'h0, 17);
      chk_counts("allr3", 4'd8, 4'd0, 4'd0, 16'h0008);

      // Word 0 is written in the same cycle as start; the first fetch must see it.
      set_row(0, 32'h0022_0020, TR, 5'd0, 1'b0, 1'b0); // ADD  $0,$1,$2
      set_row(1, 32'h2020_0005, TI, 5'd0, 1'b0, 1'b1); // ADDI $0,$1,5
      set_row(2, 32'h0C1F_0000, TJ, 5'd0, 1'b0, 1'b1); // JAL (rt bits set)
      set_row(3, 32'h2007_0000, TI, 5'd7, 1'b1, 1'b1); // ADDI $7
      run("dst0", 4, 1'b0, 1'b0, 1'b1, 32'h0022_0020, 9);
      chk_counts("dst0", 4'd1, 4'd2, 4'd1, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
